// File: rtl/console_pkg.sv
// Shared types for the console sequence controller: modes, FSM states,
// opcode constants, the datapath control bundle and the per-opcode beat count.
`timescale 1ns/1ps
package console_pkg;

    typedef enum logic [2:0] {
        MODE_RUN  = 3'b000,
        MODE_MEMW = 3'b001,
        MODE_MEMR = 3'b010,
        MODE_REGR = 3'b011,
        MODE_REGW = 3'b100
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONS  = 3'd1,
        ST_HALT  = 3'd2,
        ST_FETCH = 3'd3,
        ST_EXEC  = 3'd4
    } state_e;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_INC = 4'b0100;
    localparam logic [3:0] OP_LD  = 4'b0101;
    localparam logic [3:0] OP_ST  = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_STP = 4'b1110;

    typedef struct packed {
        logic       drw;
        logic       pcinc;
        logic       lpc;
        logic       lar;
        logic       pcadd;
        logic       arinc;
        logic       memw;
        logic       lir;
        logic       ldz;
        logic       ldc;
        logic       cin;
        logic       m;
        logic       abus;
        logic       sbus;
        logic       mbus;
        logic       selctl;
        logic [3:0] s;
    } ctrl_t;

    // Execute beats an opcode needs before the next fetch; undefined opcodes act as NOP.
    function automatic logic [1:0] beat_count(input logic [3:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_INC,
            OP_JC, OP_JZ, OP_JMP, OP_STP: return 2'd1;
            OP_LD, OP_ST:                 return 2'd2;
            default:                      return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/console_ir_decode.sv
// Pure combinational execute-beat decode: {opcode, beat index, flags} -> controls.
// Beat index 0 means "not executing" and yields an all-zero bundle.
`timescale 1ns/1ps
module console_ir_decode
    import console_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] ir,
    input  logic [1:0]       exec_beat,
    input  logic             c,
    input  logic             z,
    output ctrl_t            ctrl
);

    logic [3:0] opc;
    assign opc = 4'(ir);

    always_comb begin
        ctrl = '0;
        case (opc)
            OP_ADD: if (exec_beat == 2'd1) begin
                ctrl.abus = 1'b1; ctrl.drw = 1'b1; ctrl.ldz = 1'b1; ctrl.ldc = 1'b1;
                ctrl.s    = 4'b1001; ctrl.cin = 1'b1;
            end
            OP_SUB: if (exec_beat == 2'd1) begin
                ctrl.abus = 1'b1; ctrl.drw = 1'b1; ctrl.ldz = 1'b1; ctrl.ldc = 1'b1;
                ctrl.s    = 4'b0110;
            end
            OP_AND: if (exec_beat == 2'd1) begin
                ctrl.abus = 1'b1; ctrl.drw = 1'b1; ctrl.ldz = 1'b1;
                ctrl.s    = 4'b1011; ctrl.m = 1'b1;
            end
            OP_INC: if (exec_beat == 2'd1) begin
                ctrl.abus = 1'b1; ctrl.drw = 1'b1; ctrl.ldz = 1'b1; ctrl.ldc = 1'b1;
                ctrl.s    = 4'b0000;
            end
            OP_LD: begin
                if (exec_beat == 2'd1) begin
                    ctrl.abus = 1'b1; ctrl.lar = 1'b1; ctrl.s = 4'b1010; ctrl.m = 1'b1;
                end else if (exec_beat == 2'd2) begin
                    ctrl.mbus = 1'b1; ctrl.drw = 1'b1;
                end
            end
            OP_ST: begin
                if (exec_beat == 2'd1) begin
                    ctrl.abus = 1'b1; ctrl.lar = 1'b1; ctrl.s = 4'b1111; ctrl.m = 1'b1;
                end else if (exec_beat == 2'd2) begin
                    ctrl.abus = 1'b1; ctrl.memw = 1'b1; ctrl.s = 4'b1010; ctrl.m = 1'b1;
                end
            end
            OP_JC:  if (exec_beat == 2'd1) ctrl.pcadd = c;
            OP_JZ:  if (exec_beat == 2'd1) ctrl.pcadd = z;
            OP_JMP: if (exec_beat == 2'd1) begin
                ctrl.abus = 1'b1; ctrl.lpc = 1'b1; ctrl.s = 4'b1111; ctrl.m = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/console_seq_ctrl.sv
// Console / instruction sequencer: console modes with start-button handshake,
// and a fetch/execute beat generator for run mode. Controls decode from state.
`timescale 1ns/1ps
module console_seq_ctrl
    import console_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int OPC_W    = 4,
    parameter int MAX_EXEC = 2,
    localparam int RSEL_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [2:0]        sw,
    input  logic              start,
    input  logic              step,
    input  logic [OPC_W-1:0]  ir,
    input  logic              c,
    input  logic              z,
    output logic              drw,
    output logic              pcinc,
    output logic              lpc,
    output logic              lar,
    output logic              pcadd,
    output logic              arinc,
    output logic              memw,
    output logic              lir,
    output logic              ldz,
    output logic              ldc,
    output logic              cin,
    output logic              m,
    output logic              abus,
    output logic              sbus,
    output logic              mbus,
    output logic              selctl,
    output logic [3:0]        s,
    output logic [RSEL_W-1:0] sel_a,
    output logic [RSEL_W-1:0] sel_b,
    output logic              stop,
    output logic [1:0]        beat
);

    localparam logic [1:0]        MAX_B   = 2'(MAX_EXEC);
    localparam logic [RSEL_W-1:0] IDX_ONE = RSEL_W'(1);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [RSEL_W-1:0]  idx_q, idx_d;
    logic               first_q, first_d;
    logic [1:0]         beat_q, beat_d;
    logic               start_q;

    logic               start_edge;
    logic [3:0]         opc;
    logic [1:0]         last_beat;
    ctrl_t              dec_ctrl;
    ctrl_t              out_c;

    assign start_edge = start & ~start_q;
    assign opc        = 4'(ir);
    assign last_beat  = (beat_count(opc) > MAX_B) ? MAX_B : beat_count(opc);

    console_ir_decode #(.OPC_W(OPC_W)) u_dec (
        .ir        (ir),
        .exec_beat (beat_q),
        .c         (c),
        .z         (z),
        .ctrl      (dec_ctrl)
    );

    // ir is expected to hold the fetched opcode from FETCH through the last execute beat.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        first_d = first_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge && sw <= 3'b100) begin
                    mode_d  = mode_e'(sw);
                    first_d = 1'b1;
                    state_d = ST_CONS;
                end
            end
            ST_CONS: begin
                first_d = 1'b0;
                state_d = ST_HALT;
                if (mode_q == MODE_REGW) idx_d = idx_q + IDX_ONE;
                if (mode_q == MODE_REGR) idx_d = idx_q + IDX_ONE + IDX_ONE;
            end
            ST_HALT: begin
                if (start_edge) state_d = (mode_q == MODE_RUN) ? ST_FETCH : ST_CONS;
            end
            ST_FETCH: begin
                if (last_beat == 2'd0) begin
                    state_d = step ? ST_HALT : ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                    beat_d  = 2'd1;
                end
            end
            ST_EXEC: begin
                if (beat_q >= last_beat) begin
                    state_d = (step || opc == OP_STP) ? ST_HALT : ST_FETCH;
                    beat_d  = 2'd0;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_RUN;
            idx_q   <= '0;
            first_q <= 1'b0;
            beat_q  <= 2'd0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            beat_q  <= beat_d;
            start_q <= start;
        end
    end

    always_comb begin
        out_c = '0;
        sel_a = '0;
        sel_b = '0;
        case (state_q)
            ST_CONS: begin
                out_c.selctl = 1'b1;
                case (mode_q)
                    MODE_RUN: begin
                        out_c.sbus = 1'b1;
                        out_c.lpc  = 1'b1;
                    end
                    MODE_MEMW: begin
                        out_c.sbus = 1'b1;
                        if (first_q) out_c.lar = 1'b1;
                        else begin
                            out_c.memw  = 1'b1;
                            out_c.arinc = 1'b1;
                        end
                    end
                    MODE_MEMR: begin
                        if (first_q) begin
                            out_c.sbus = 1'b1;
                            out_c.lar  = 1'b1;
                        end else begin
                            out_c.mbus  = 1'b1;
                            out_c.arinc = 1'b1;
                        end
                    end
                    MODE_REGW: begin
                        out_c.sbus = 1'b1;
                        out_c.drw  = 1'b1;
                        sel_a      = idx_q;
                    end
                    MODE_REGR: begin
                        sel_a = idx_q;
                        sel_b = idx_q + IDX_ONE;
                    end
                    default: ;
                endcase
            end
            ST_FETCH: begin
                out_c.lir   = 1'b1;
                out_c.pcinc = 1'b1;
            end
            ST_EXEC: out_c = dec_ctrl;
            default: ;
        endcase
    end

    assign drw    = out_c.drw;
    assign pcinc  = out_c.pcinc;
    assign lpc    = out_c.lpc;
    assign lar    = out_c.lar;
    assign pcadd  = out_c.pcadd;
    assign arinc  = out_c.arinc;
    assign memw   = out_c.memw;
    assign lir    = out_c.lir;
    assign ldz    = out_c.ldz;
    assign ldc    = out_c.ldc;
    assign cin    = out_c.cin;
    assign m      = out_c.m;
    assign abus   = out_c.abus;
    assign sbus   = out_c.sbus;
    assign mbus   = out_c.mbus;
    assign selctl = out_c.selctl;
    assign s      = out_c.s;
    assign stop   = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign beat   = (state_q == ST_EXEC) ? beat_q : 2'd0;

endmodule

// File: tb/tb_console_seq_ctrl.sv
// Directed bench for console_seq_ctrl: console modes, run-mode beat sequences,
// async clear, start-edge handling and execute-beat truncation (second instance).
`timescale 1ns/1ps
module tb_console_seq_ctrl;
    import console_pkg::*;

    localparam logic [15:0] K_DRW    = 16'h8000;
    localparam logic [15:0] K_PCINC  = 16'h4000;
    localparam logic [15:0] K_LPC    = 16'h2000;
    localparam logic [15:0] K_LAR    = 16'h1000;
    localparam logic [15:0] K_PCADD  = 16'h0800;
    localparam logic [15:0] K_ARINC  = 16'h0400;
    localparam logic [15:0] K_MEMW   = 16'h0200;
    localparam logic [15:0] K_LIR    = 16'h0100;
    localparam logic [15:0] K_LDZ    = 16'h0080;
    localparam logic [15:0] K_LDC    = 16'h0040;
    localparam logic [15:0] K_CIN    = 16'h0020;
    localparam logic [15:0] K_M      = 16'h0010;
    localparam logic [15:0] K_ABUS   = 16'h0008;
    localparam logic [15:0] K_SBUS   = 16'h0004;
    localparam logic [15:0] K_MBUS   = 16'h0002;
    localparam logic [15:0] K_SELCTL = 16'h0001;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [2:0] sw = 3'b000;
    logic       start = 1'b0;
    logic       step = 1'b0;
    logic [3:0] ir = 4'b0000;
    logic       c = 1'b0;
    logic       z = 1'b0;

    logic drw, pcinc, lpc, lar, pcadd, arinc, memw, lir, ldz, ldc, cin, m, abus, sbus, mbus, selctl, stop;
    logic [3:0] s;
    logic [1:0] sel_a, sel_b, beat;
    logic drw1, pcinc1, lpc1, lar1, pcadd1, arinc1, memw1, lir1, ldz1, ldc1, cin1, m1, abus1, sbus1, mbus1, selctl1, stop1;
    logic [3:0] s1;
    logic [1:0] sel_a1, sel_b1, beat1;

    logic [15:0] ctl, ctl1;
    assign ctl  = {drw, pcinc, lpc, lar, pcadd, arinc, memw, lir, ldz, ldc, cin, m, abus, sbus, mbus, selctl};
    assign ctl1 = {drw1, pcinc1, lpc1, lar1, pcadd1, arinc1, memw1, lir1, ldz1, ldc1, cin1, m1, abus1, sbus1, mbus1, selctl1};

    int vectors = 0;
    int miscompares = 0;
    int lir_cnt = 0;
    int lir1_cnt = 0;
    int drw1_cnt = 0;

    always #5 clk = ~clk;

    console_seq_ctrl #(.NUM_REGS(4), .OPC_W(4), .MAX_EXEC(2)) dut (
        .clk(clk), .clr(clr), .sw(sw), .start(start), .step(step), .ir(ir), .c(c), .z(z),
        .drw(drw), .pcinc(pcinc), .lpc(lpc), .lar(lar), .pcadd(pcadd), .arinc(arinc),
        .memw(memw), .lir(lir), .ldz(ldz), .ldc(ldc), .cin(cin), .m(m), .abus(abus),
        .sbus(sbus), .mbus(mbus), .selctl(selctl), .s(s), .sel_a(sel_a), .sel_b(sel_b),
        .stop(stop), .beat(beat)
    );

    console_seq_ctrl #(.NUM_REGS(4), .OPC_W(4), .MAX_EXEC(1)) dut1 (
        .clk(clk), .clr(clr), .sw(sw), .start(start), .step(step), .ir(ir), .c(c), .z(z),
        .drw(drw1), .pcinc(pcinc1), .lpc(lpc1), .lar(lar1), .pcadd(pcadd1), .arinc(arinc1),
        .memw(memw1), .lir(lir1), .ldz(ldz1), .ldc(ldc1), .cin(cin1), .m(m1), .abus(abus1),
        .sbus(sbus1), .mbus(mbus1), .selctl(selctl1), .s(s1), .sel_a(sel_a1), .sel_b(sel_b1),
        .stop(stop1), .beat(beat1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("miscompare at %s", tag);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        lir_cnt  += int'(lir);
        lir1_cnt += int'(lir1);
        drw1_cnt += int'(drw1);
    endtask

    task automatic press();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        clr   = 1'b1;
        start = 1'b0;
        step  = 1'b0;
        c     = 1'b0;
        z     = 1'b0;
        tick();
        clr = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("reset_ctl", 32'(ctl), 32'h0);
        chk("reset_stop", 32'(stop), 32'd1);
        chk("reset_beat", 32'(beat), 32'd0);
        clr = 1'b0;
        tick();
        chk("idle_stop", 32'(stop), 32'd1);

        // REGW: five writes walk sel_a 0,1,2,3,0; sw changes ignored once latched
        do_reset();
        sw = 3'b100;
        press();
        chk("regw0_ctl", 32'(ctl), 32'(K_SBUS | K_DRW | K_SELCTL));
        chk("regw0_sel", 32'(sel_a), 32'd0);
        tick();
        chk("regw0_stop", 32'(stop), 32'd1);
        sw = 3'b001;
        for (int i = 1; i < 5; i++) begin
            press();
            chk($sformatf("regw%0d_ctl", i), 32'(ctl), 32'(K_SBUS | K_DRW | K_SELCTL));
            chk($sformatf("regw%0d_sel", i), 32'(sel_a), 32'(i % 4));
            tick();
            chk($sformatf("regw%0d_stop", i), 32'(stop), 32'd1);
        end

        // REGR: pairs of registers
        do_reset();
        sw = 3'b011;
        press();
        chk("regr0_ctl", 32'(ctl), 32'(K_SELCTL));
        chk("regr0_a", 32'(sel_a), 32'd0);
        chk("regr0_b", 32'(sel_b), 32'd1);
        tick();
        press();
        chk("regr1_a", 32'(sel_a), 32'd2);
        chk("regr1_b", 32'(sel_b), 32'd3);

        // MEMW: address load once, then writes with increment
        do_reset();
        sw = 3'b001;
        press();
        chk("memw1_ctl", 32'(ctl), 32'(K_SBUS | K_LAR | K_SELCTL));
        tick();
        press();
        chk("memw2_ctl", 32'(ctl), 32'(K_SBUS | K_MEMW | K_ARINC | K_SELCTL));
        tick();
        press();
        chk("memw3_ctl", 32'(ctl), 32'(K_SBUS | K_MEMW | K_ARINC | K_SELCTL));
        tick();
        chk("memw3_stop", 32'(stop), 32'd1);

        // MEMR
        do_reset();
        sw = 3'b010;
        press();
        chk("memr1_ctl", 32'(ctl), 32'(K_SBUS | K_LAR | K_SELCTL));
        tick();
        press();
        chk("memr2_ctl", 32'(ctl), 32'(K_MBUS | K_ARINC | K_SELCTL));

        // RUN: ADD, LD, JC(c=0), STP with step=0
        do_reset();
        sw = 3'b000;
        ir = OP_NOP;
        press();
        chk("run_pc_ctl", 32'(ctl), 32'(K_SBUS | K_LPC | K_SELCTL));
        tick();
        chk("run_pc_stop", 32'(stop), 32'd1);
        ir = OP_ADD;
        lir_cnt = 0;
        press();
        chk("add_fetch", 32'(ctl), 32'(K_LIR | K_PCINC));
        chk("add_fetch_beat", 32'(beat), 32'd0);
        tick();
        chk("add_e1", 32'(ctl), 32'(K_ABUS | K_DRW | K_LDZ | K_LDC | K_CIN));
        chk("add_s", 32'(s), 32'b1001);
        chk("add_beat", 32'(beat), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        ir = OP_LD;
        chk("ld_fetch", 32'(ctl), 32'(K_LIR | K_PCINC));
        tick();
        chk("ld_e1", 32'(ctl), 32'(K_ABUS | K_LAR | K_M));
        chk("ld_e1_s", 32'(s), 32'b1010);
        tick();
        chk("ld_e2", 32'(ctl), 32'(K_MBUS | K_DRW));
        chk("ld_e2_beat", 32'(beat), 32'd2);
        tick();
        ir = OP_JC;
        chk("jc_fetch", 32'(ctl), 32'(K_LIR | K_PCINC));
        tick();
        chk("jc_e1", 32'(ctl), 32'h0);
        chk("jc_beat", 32'(beat), 32'd1);
        tick();
        ir = OP_STP;
        chk("stp_fetch", 32'(ctl), 32'(K_LIR | K_PCINC));
        tick();
        chk("stp_e1", 32'(ctl), 32'h0);
        chk("stp_e1_stop", 32'(stop), 32'd0);
        tick();
        chk("stp_halt", 32'(stop), 32'd1);
        chk("lir_count", 32'(lir_cnt), 32'd4);

        // RUN with step=1, JZ taken; start rising as HALT is entered must not count
        do_reset();
        sw = 3'b000;
        press();
        tick();
        step = 1'b1;
        ir = OP_JZ;
        z = 1'b1;
        press();
        chk("jz_fetch", 32'(ctl), 32'(K_LIR | K_PCINC));
        tick();
        chk("jz_e1", 32'(ctl), 32'(K_PCADD));
        start = 1'b1;
        tick();
        chk("jz_halt", 32'(stop), 32'd1);
        tick();
        tick();
        chk("jz_hold_halt", 32'(stop), 32'd1);
        start = 1'b0;
        tick();
        press();
        chk("jz_resume", 32'(ctl), 32'(K_LIR | K_PCINC));

        // Asynchronous clear in the middle of ADD's execute beat
        do_reset();
        sw = 3'b000;
        press();
        tick();
        ir = OP_ADD;
        press();
        tick();
        chk("clr_pre", 32'(ctl), 32'(K_ABUS | K_DRW | K_LDZ | K_LDC | K_CIN));
        clr = 1'b1;
        #1;
        chk("clr_ctl", 32'(ctl), 32'h0);
        chk("clr_stop", 32'(stop), 32'd1);
        tick();
        clr = 1'b0;
        tick();
        chk("clr_idle_stop", 32'(stop), 32'd1);
        chk("clr_idle_ctl", 32'(ctl), 32'h0);
        sw = 3'b100;
        press();
        chk("clr_idle_regw", 32'(ctl), 32'(K_SBUS | K_DRW | K_SELCTL));

        // MAX_EXEC = 1 instance: LD truncated to E1; held start gives one advance
        do_reset();
        sw = 3'b000;
        press();
        tick();
        ir = OP_LD;
        drw1_cnt = 0;
        press();
        tick();
        chk("trunc_e1", 32'(ctl1), 32'(K_ABUS | K_LAR | K_M));
        chk("trunc_beat", 32'(beat1), 32'd1);
        tick();
        chk("trunc_fetch", 32'(ctl1), 32'(K_LIR | K_PCINC));
        ir = OP_NOP;
        step = 1'b1;
        tick();
        chk("trunc_halt", 32'(stop1), 32'd1);
        lir1_cnt = 0;
        start = 1'b1;
        repeat (10) tick();
        start = 1'b0;
        chk("held_start_adv", 32'(lir1_cnt), 32'd1);
        chk("held_start_stop", 32'(stop1), 32'd1);
        chk("trunc_no_drw", 32'(drw1_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
